// File: rtl/stopwatch_lap_controller.sv
// Stopwatch start/stop/lap/reset FSM with BCD mm:ss.cc counter and frozen lap display.
// Define STOPWATCH_OVERFLOW_HOLD_EN to saturate at MAX_MINUTES:59.99 with sticky overflow.
module stopwatch_lap_controller #(
    parameter int unsigned MAX_MINUTES = 59
) (
    input  logic       clk_ms,
    input  logic       reset,
    input  logic       start_stop_pls,
    input  logic       lap_reset_pls,
    input  logic       tick_10ms,
    output logic       running,
    output logic       lap_active,
    output logic [7:0] disp_cs,
    output logic [7:0] disp_s,
    output logic [7:0] disp_m,
    output logic       overflow
);

    localparam logic [7:0] MaxMinBcd = {4'(MAX_MINUTES / 10), 4'(MAX_MINUTES % 10)};

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRunning = 2'd1,
        StPaused  = 2'd2,
        StLap     = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cs_q, cs_d, s_q, s_d, m_q, m_d;
    logic [23:0] lap_q, lap_d;
    logic       overflow_q, overflow_d;

    logic [8:0] cs_inc, s_inc, m_inc;
    logic       cnt_en, at_max, clear, capture;

    // Returns {carry, next}; carry set and value wraps to 00 when v equals lim.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        if (v == lim) begin
            return 9'h100;
        end else if (v[3:0] == 4'd9) begin
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        end else begin
            return {1'b0, v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        capture = 1'b0;
        // start_stop has priority; lap_reset only acts when start_stop is absent.
        unique case (state_q)
            StIdle: begin
                if (start_stop_pls) state_d = StRunning;
            end
            StRunning: begin
                if (start_stop_pls) begin
                    state_d = StPaused;
                end else if (lap_reset_pls) begin
                    state_d = StLap;
                    capture = 1'b1;
                end
            end
            StLap: begin
                if (start_stop_pls) begin
                    state_d = StPaused;
                end else if (lap_reset_pls) begin
                    state_d = StRunning;
                end
            end
            StPaused: begin
                if (start_stop_pls) begin
                    state_d = StRunning;
                end else if (lap_reset_pls) begin
                    state_d = StIdle;
                    clear   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cs_inc = bcd_inc(cs_q, 8'h99);
        s_inc  = bcd_inc(s_q, 8'h59);
        m_inc  = bcd_inc(m_q, MaxMinBcd);
        at_max = cs_inc[8] & s_inc[8] & m_inc[8];
        cnt_en = tick_10ms & ((state_q == StRunning) | (state_q == StLap));

        cs_d  = cs_q;
        s_d   = s_q;
        m_d   = m_q;
        lap_d = lap_q;

        if (clear) begin
            cs_d  = 8'h00;
            s_d   = 8'h00;
            m_d   = 8'h00;
            lap_d = 24'h0;
        end else begin
            // Capture uses the registered value, so a coincident tick is excluded.
            if (capture) lap_d = {m_q, s_q, cs_q};
            if (cnt_en) begin
`ifdef STOPWATCH_OVERFLOW_HOLD_EN
                if (!at_max) begin
                    cs_d = cs_inc[7:0];
                    if (cs_inc[8]) s_d = s_inc[7:0];
                    if (cs_inc[8] && s_inc[8]) m_d = m_inc[7:0];
                end
`else
                cs_d = cs_inc[7:0];
                if (cs_inc[8]) s_d = s_inc[7:0];
                if (cs_inc[8] && s_inc[8]) m_d = m_inc[7:0];
`endif
            end
        end

`ifdef STOPWATCH_OVERFLOW_HOLD_EN
        overflow_d = overflow_q;
        if (clear) begin
            overflow_d = 1'b0;
        end else if (cnt_en && at_max) begin
            overflow_d = 1'b1;
        end
`else
        overflow_d = cnt_en & at_max;
`endif
    end

    always_ff @(posedge clk_ms) begin
        if (reset) begin
            state_q    <= StIdle;
            cs_q       <= 8'h00;
            s_q        <= 8'h00;
            m_q        <= 8'h00;
            lap_q      <= 24'h0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_q       <= cs_d;
            s_q        <= s_d;
            m_q        <= m_d;
            lap_q      <= lap_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        running    = (state_q == StRunning) | (state_q == StLap);
        lap_active = (state_q == StLap);
        overflow   = overflow_q;
        if (state_q == StLap) begin
            {disp_m, disp_s, disp_cs} = lap_q;
        end else begin
            {disp_m, disp_s, disp_cs} = {m_q, s_q, cs_q};
        end
    end

endmodule

// File: tb/tb_stopwatch_lap_controller.sv
// Directed self-checking bench for stopwatch_lap_controller (MAX_MINUTES=1).
// Expectations follow STOPWATCH_OVERFLOW_HOLD_EN when defined.
module tb_stopwatch_lap_controller;

    logic       clk_ms = 1'b0;
    logic       reset = 1'b0;
    logic       start_stop_pls = 1'b0;
    logic       lap_reset_pls = 1'b0;
    logic       tick_10ms = 1'b0;
    logic       running, lap_active, overflow;
    logic [7:0] disp_cs, disp_s, disp_m;

    int n_assert = 0;
    int n_fail = 0;

    stopwatch_lap_controller #(
        .MAX_MINUTES(1)
    ) dut (
        .clk_ms        (clk_ms),
        .reset         (reset),
        .start_stop_pls(start_stop_pls),
        .lap_reset_pls (lap_reset_pls),
        .tick_10ms     (tick_10ms),
        .running       (running),
        .lap_active    (lap_active),
        .disp_cs       (disp_cs),
        .disp_s        (disp_s),
        .disp_m        (disp_m),
        .overflow      (overflow)
    );

    always #5 clk_ms = ~clk_ms;

    // Inputs applied 1 time unit after an edge, outputs sampled 1 unit after the next edge.
    task automatic cycle(input logic ss, input logic lr, input logic tk);
        start_stop_pls = ss;
        lap_reset_pls  = lr;
        tick_10ms      = tk;
        @(posedge clk_ms);
        #1;
        start_stop_pls = 1'b0;
        lap_reset_pls  = 1'b0;
        tick_10ms      = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk_ms);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_disp(input string tag, input logic [23:0] exp);
        n_assert++;
        assert ({disp_m, disp_s, disp_cs} === exp)
        else begin
            n_fail++;
            $error("FAIL %s disp observed=%h expected=%h", tag, {disp_m, disp_s, disp_cs}, exp);
        end
    endtask

    // Flags ordered {running, lap_active, overflow}.
    task automatic chk_flags(input string tag, input logic [2:0] exp);
        n_assert++;
        assert ({running, lap_active, overflow} === exp)
        else begin
            n_fail++;
            $error("FAIL %s flags observed=%b expected=%b", tag,
                   {running, lap_active, overflow}, exp);
        end
    endtask

    initial begin
        @(posedge clk_ms);
        #1;
        do_reset();
        chk_disp("reset", 24'h000000);
        chk_flags("reset", 3'b000);

        // Basic run with cs->s carry
        cycle(1'b1, 1'b0, 1'b0);
        chk_flags("start", 3'b100);
        tick_n(150);
        chk_disp("run150", 24'h000150);
        chk_flags("run150", 3'b100);

        // Lap freeze and release
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        tick_n(37);
        cycle(1'b0, 1'b1, 1'b0);
        chk_disp("lap_enter", 24'h000037);
        chk_flags("lap_enter", 3'b110);
        tick_n(20);
        chk_disp("lap_frozen", 24'h000037);
        cycle(1'b0, 1'b1, 1'b0);
        chk_disp("lap_release", 24'h000057);
        chk_flags("lap_release", 3'b100);
        cycle(1'b0, 1'b1, 1'b1);
        chk_disp("lap_tick_preinc", 24'h000057);
        cycle(1'b0, 1'b1, 1'b0);
        chk_disp("lap_tick_live", 24'h000058);

        // Stop with coincident tick counts; paused ignores ticks
        cycle(1'b1, 1'b0, 1'b1);
        chk_disp("stop_tick", 24'h000059);
        chk_flags("stop_tick", 3'b000);
        tick_n(10);
        chk_disp("paused_ticks", 24'h000059);
        cycle(1'b1, 1'b0, 1'b1);
        chk_disp("start_tick_nocount", 24'h000059);
        chk_flags("restart", 3'b100);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk_disp("paused_clear", 24'h000000);
        chk_flags("paused_clear", 3'b000);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        chk_disp("idle_ignore", 24'h000000);
        chk_flags("idle_ignore", 3'b000);

        // Both pulses together: start_stop wins
        cycle(1'b1, 1'b0, 1'b0);
        tick_n(5);
        cycle(1'b1, 1'b1, 1'b0);
        chk_flags("both_pulses", 3'b000);
        chk_disp("both_pulses", 24'h000005);
        cycle(1'b1, 1'b0, 1'b0);
        tick_n(3);
        cycle(1'b0, 1'b1, 1'b0);
        chk_disp("lap2", 24'h000008);
        tick_n(2);
        chk_disp("lap2_frozen", 24'h000008);
        cycle(1'b1, 1'b0, 1'b0);
        chk_disp("lap_to_paused_live", 24'h000010);
        chk_flags("lap_to_paused", 3'b000);

        // Overflow at 01:59.99
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        tick_n(5999);
        chk_disp("pre_min_carry", 24'h005999);
        cycle(1'b0, 1'b0, 1'b1);
        chk_disp("min_carry", 24'h010000);
        tick_n(5999);
        chk_disp("at_max", 24'h015999);
        chk_flags("at_max", 3'b100);
        cycle(1'b0, 1'b0, 1'b1);
`ifdef STOPWATCH_OVERFLOW_HOLD_EN
        chk_disp("ovf_hold", 24'h015999);
        chk_flags("ovf_hold", 3'b101);
        tick_n(3);
        chk_disp("ovf_hold2", 24'h015999);
        chk_flags("ovf_sticky", 3'b101);
        cycle(1'b1, 1'b0, 1'b0);
        chk_flags("ovf_paused", 3'b001);
        cycle(1'b0, 1'b1, 1'b0);
        chk_disp("ovf_cleared", 24'h000000);
        chk_flags("ovf_cleared", 3'b000);
`else
        chk_disp("ovf_wrap", 24'h000000);
        chk_flags("ovf_pulse", 3'b101);
        cycle(1'b0, 1'b0, 1'b0);
        chk_flags("ovf_drop", 3'b100);
        cycle(1'b0, 1'b0, 1'b1);
        chk_disp("after_wrap", 24'h000001);
`endif

        // Reset wins over coincident tick and start_stop
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        tick_n(3);
        reset          = 1'b1;
        start_stop_pls = 1'b1;
        tick_10ms      = 1'b1;
        @(posedge clk_ms);
        #1;
        reset          = 1'b0;
        start_stop_pls = 1'b0;
        tick_10ms      = 1'b0;
        chk_disp("reset_midrun", 24'h000000);
        chk_flags("reset_midrun", 3'b000);
        cycle(1'b0, 1'b0, 1'b1);
        chk_disp("post_reset_idle", 24'h000000);
        chk_flags("post_reset_idle", 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
